// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - 6502-class RESET/NMI/BRK/multi-IRQ interrupt sequencer
module interrupt_sequencer #(
  parameter int                          DATA_WIDTH   = 8,
  parameter int                          N_IRQ        = 1,
  parameter logic [DATA_WIDTH-1:0]       STACK_PAGE   = 8'h01,
  parameter logic [2*DATA_WIDTH-1:0]     EXT_VEC_BASE = 16'hFFE0
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      RDY,
  input  logic                      NMI,
  input  logic [N_IRQ-1:0]          IRQ,
  input  logic [N_IRQ-1:0]          irq_en,
  input  logic                      i_flag,
  input  logic                      insn_boundary,
  input  logic                      brk,
  input  logic [2*DATA_WIDTH-1:0]   pc,
  input  logic [DATA_WIDTH-1:0]     psr,
  input  logic [DATA_WIDTH-1:0]     sp,
  input  logic [DATA_WIDTH-1:0]     data_in,
  output logic                      busy,
  output logic [2*DATA_WIDTH-1:0]   addr,
  output logic                      addr_valid,
  output logic                      rw,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      sp_dec,
  output logic                      pc_load,
  output logic [2*DATA_WIDTH-1:0]   pc_new,
  output logic                      set_i,
  output logic [N_IRQ-1:0]          irq_ack
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = 2 * DATA_WIDTH;

  // Fixed vectors sit at the top of the address space, counted down from all-ones
  localparam logic [AW-1:0] VEC_NMI = {AW{1'b1}} - AW'(5);
  localparam logic [AW-1:0] VEC_RES = {AW{1'b1}} - AW'(3);
  localparam logic [AW-1:0] VEC_IRQ = {AW{1'b1}} - AW'(1);

  typedef enum logic [2:0] {
    IDLE,
    PUSH_PCH,
    PUSH_PCL,
    PUSH_P,
    VEC_LO,
    VEC_HI,
    DONE
  } state_t;

  state_t            state;
  logic              reset_pending;
  logic              nmi_pending;
  logic              nmi_q;
  logic              seq_reset;
  logic              seq_maskable;
  logic [AW-1:0]     vec;
  logic [N_IRQ-1:0]  ack_mask;
  logic [DW-1:0]     sp_work;
  logic [DW-1:0]     pcl_q;
  logic [DW-1:0]     p_q;
  logic [DW-1:0]     vec_lo_q;

  logic              nmi_edge;
  logic              nmi_now;
  logic              irq_hit;
  logic [N_IRQ-1:0]  irq_oh;
  logic [AW-1:0]     irq_vec;
  logic              start_reset;
  logic              start_nmi;
  logic              start_brk;
  logic              start_irq;
  logic              start;
  logic [AW-1:0]     start_vec;
  logic [DW-1:0]     p_start;
  logic              in_push;
  logic              hijack;
  logic [AW-1:0]     vec_eff;

  assign nmi_edge = nmi_q & ~NMI;
  assign nmi_now  = nmi_pending | nmi_edge;

  // Pick the lowest-numbered enabled, asserted IRQ channel and its vector
  always_comb begin
    irq_hit = 1'b0;
    irq_oh  = '0;
    irq_vec = VEC_IRQ;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (!IRQ[k] && irq_en[k]) begin
        irq_hit   = 1'b1;
        irq_oh    = '0;
        irq_oh[k] = 1'b1;
        irq_vec   = (k == 0) ? VEC_IRQ : EXT_VEC_BASE + AW'(2 * k - 2);
      end
    end
    if (i_flag) begin
      irq_hit = 1'b0;
    end
  end

  // Start arbitration in IDLE: RESET > NMI > BRK > IRQ
  always_comb begin
    start_reset = reset_pending;
    start_nmi   = !reset_pending && insn_boundary && nmi_now;
    start_brk   = !reset_pending && insn_boundary && !nmi_now && brk;
    start_irq   = !reset_pending && insn_boundary && !nmi_now && !brk && irq_hit;
    start       = start_reset | start_nmi | start_brk | start_irq;
    if (start_reset) begin
      start_vec = VEC_RES;
    end else if (start_nmi) begin
      start_vec = VEC_NMI;
    end else if (start_brk) begin
      start_vec = VEC_IRQ;
    end else begin
      start_vec = irq_vec;
    end
    p_start    = psr;
    p_start[5] = 1'b1;
    p_start[4] = start_brk;
  end

  // A pending NMI seen during the pushes of a BRK/IRQ sequence steals its vector
  always_comb begin
    in_push = (state == PUSH_PCH) || (state == PUSH_PCL) || (state == PUSH_P);
    hijack  = in_push && seq_maskable && nmi_now;
    vec_eff = hijack ? VEC_NMI : vec;
  end

  // Sequencer state, NMI edge capture and registered bus/strobe outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state         <= IDLE;
      reset_pending <= 1'b1;
      nmi_pending   <= 1'b0;
      nmi_q         <= 1'b1;
      seq_reset     <= 1'b0;
      seq_maskable  <= 1'b0;
      vec           <= '0;
      ack_mask      <= '0;
      sp_work       <= '0;
      pcl_q         <= '0;
      p_q           <= '0;
      vec_lo_q      <= '0;
      busy          <= 1'b1;
      addr          <= '0;
      addr_valid    <= 1'b0;
      rw            <= 1'b1;
      data_out      <= '0;
      sp_dec        <= 1'b0;
      pc_load       <= 1'b0;
      pc_new        <= '0;
      set_i         <= 1'b0;
      irq_ack       <= '0;
    end else begin
      nmi_q <= NMI;
      if (nmi_edge) begin
        nmi_pending <= 1'b1;
      end
      if (hijack) begin
        vec          <= VEC_NMI;
        ack_mask     <= '0;
        seq_maskable <= 1'b0;
        nmi_pending  <= 1'b0;
      end
      if (RDY) begin
        case (state)
          IDLE: begin
            if (start) begin
              state        <= PUSH_PCH;
              busy         <= 1'b1;
              seq_reset    <= start_reset;
              seq_maskable <= start_brk | start_irq;
              vec          <= start_vec;
              ack_mask     <= start_irq ? irq_oh : '0;
              pcl_q        <= pc[DW-1:0];
              p_q          <= p_start;
              sp_work      <= sp - DW'(1);
              addr         <= {STACK_PAGE, sp};
              addr_valid   <= 1'b1;
              rw           <= start_reset;
              data_out     <= start_reset ? '0 : pc[AW-1:DW];
              sp_dec       <= 1'b1;
              if (start_nmi) begin
                nmi_pending <= 1'b0;
              end
            end else begin
              busy <= 1'b0;
            end
          end
          PUSH_PCH: begin
            state    <= PUSH_PCL;
            addr     <= {STACK_PAGE, sp_work};
            sp_work  <= sp_work - DW'(1);
            data_out <= seq_reset ? '0 : pcl_q;
          end
          PUSH_PCL: begin
            state    <= PUSH_P;
            addr     <= {STACK_PAGE, sp_work};
            sp_work  <= sp_work - DW'(1);
            data_out <= seq_reset ? '0 : p_q;
          end
          PUSH_P: begin
            state    <= VEC_LO;
            addr     <= vec_eff;
            rw       <= 1'b1;
            data_out <= '0;
            sp_dec   <= 1'b0;
          end
          VEC_LO: begin
            state    <= VEC_HI;
            vec_lo_q <= data_in;
            addr     <= addr + AW'(1);
          end
          VEC_HI: begin
            state      <= DONE;
            pc_new     <= {data_in, vec_lo_q};
            pc_load    <= 1'b1;
            set_i      <= 1'b1;
            irq_ack    <= ack_mask;
            addr       <= '0;
            addr_valid <= 1'b0;
          end
          DONE: begin
            state         <= IDLE;
            reset_pending <= 1'b0;
            busy          <= 1'b0;
            pc_load       <= 1'b0;
            set_i         <= 1'b0;
            irq_ack       <= '0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - directed self-checking bench for interrupt_sequencer
module tb_interrupt_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        RDY;
  logic        NMI;
  logic [3:0]  IRQ;
  logic [3:0]  irq_en;
  logic        i_flag;
  logic        insn_boundary;
  logic        brk;
  logic [15:0] pc;
  logic [7:0]  psr;
  logic [7:0]  sp;
  logic [7:0]  data_in;
  logic        busy;
  logic [15:0] addr;
  logic        addr_valid;
  logic        rw;
  logic [7:0]  data_out;
  logic        sp_dec;
  logic        pc_load;
  logic [15:0] pc_new;
  logic        set_i;
  logic [3:0]  irq_ack;

  int n_checks = 0;
  int n_fail   = 0;

  interrupt_sequencer #(
    .DATA_WIDTH   (8),
    .N_IRQ        (4),
    .STACK_PAGE   (8'h01),
    .EXT_VEC_BASE (16'hFFE0)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .RDY           (RDY),
    .NMI           (NMI),
    .IRQ           (IRQ),
    .irq_en        (irq_en),
    .i_flag        (i_flag),
    .insn_boundary (insn_boundary),
    .brk           (brk),
    .pc            (pc),
    .psr           (psr),
    .sp            (sp),
    .data_in       (data_in),
    .busy          (busy),
    .addr          (addr),
    .addr_valid    (addr_valid),
    .rw            (rw),
    .data_out      (data_out),
    .sp_dec        (sp_dec),
    .pc_load       (pc_load),
    .pc_new        (pc_new),
    .set_i         (set_i),
    .irq_ack       (irq_ack)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'hFFFA: return 8'h11;
      16'hFFFB: return 8'h90;
      16'hFFFC: return 8'h00;
      16'hFFFD: return 8'h80;
      16'hFFFE: return 8'h22;
      16'hFFFF: return 8'hA0;
      16'hFFE0: return 8'h33;
      16'hFFE1: return 8'hB0;
      default:  return 8'hEE;
    endcase
  endfunction

  assign data_in = mem_rd(addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; the decoder model decrements SP when it sees an advancing sp_dec
  task automatic tick();
    logic dec;
    dec = sp_dec && RDY;
    @(posedge CLK);
    #1;
    if (dec) sp = sp - 8'd1;
  endtask

  // Inputs already present for the start cycle T0; checks T1 through the return to idle
  task automatic run_seq(input string tag, input logic is_reset,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [15:0] vec, input logic [15:0] pc_exp,
                         input logic [3:0] ack, input logic nmi_drop, input int stall);
    logic [7:0] sp0;
    logic [7:0] pb [3];
    pb[0] = b0;
    pb[1] = b1;
    pb[2] = b2;
    sp0 = sp;
    tick();
    insn_boundary = 1'b0;
    brk = 1'b0;
    IRQ = 4'hF;
    check({tag, ".busy"}, busy, 1);
    for (int i = 0; i < 3; i++) begin
      check({tag, ".push_addr"}, addr, {8'h01, sp0 - 8'(i)});
      check({tag, ".push_rw"}, rw, is_reset);
      check({tag, ".push_valid"}, addr_valid, 1);
      check({tag, ".push_spdec"}, sp_dec, 1);
      if (!is_reset) check({tag, ".push_data"}, data_out, pb[i]);
      if (nmi_drop && i == 1) NMI = 1'b0;
      tick();
    end
    check({tag, ".vlo_addr"}, addr, vec);
    check({tag, ".vlo_rw"}, rw, 1);
    check({tag, ".vlo_spdec"}, sp_dec, 0);
    for (int s = 0; s < stall; s++) begin
      RDY = 1'b0;
      tick();
      check({tag, ".stall_addr"}, addr, vec);
      check({tag, ".stall_pcload"}, pc_load, 0);
    end
    RDY = 1'b1;
    tick();
    check({tag, ".vhi_addr"}, addr, vec + 16'd1);
    check({tag, ".vhi_pcload"}, pc_load, 0);
    tick();
    check({tag, ".pc_load"}, pc_load, 1);
    check({tag, ".pc_new"}, pc_new, pc_exp);
    check({tag, ".set_i"}, set_i, 1);
    check({tag, ".irq_ack"}, irq_ack, ack);
    check({tag, ".done_busy"}, busy, 1);
    tick();
    check({tag, ".idle_busy"}, busy, 0);
    check({tag, ".idle_pcload"}, pc_load, 0);
    check({tag, ".idle_ack"}, irq_ack, 0);
    check({tag, ".idle_valid"}, addr_valid, 0);
  endtask

  initial begin
    RST_N = 1'b0; RDY = 1'b1; NMI = 1'b1; IRQ = 4'hF; irq_en = 4'h0;
    i_flag = 1'b0; insn_boundary = 1'b0; brk = 1'b0;
    pc = 16'h0000; psr = 8'h00; sp = 8'hFD;

    tick();
    tick();
    check("rst.busy", busy, 1);
    check("rst.valid", addr_valid, 0);
    check("rst.rw", rw, 1);
    check("rst.data_out", data_out, 0);
    check("rst.sp_dec", sp_dec, 0);
    check("rst.pc_load", pc_load, 0);
    check("rst.pc_new", pc_new, 0);
    check("rst.set_i", set_i, 0);
    check("rst.irq_ack", irq_ack, 0);

    RST_N = 1'b1;
    run_seq("reset", 1'b1, 8'h00, 8'h00, 8'h00, 16'hFFFC, 16'h8000, 4'h0, 1'b0, 0);
    check("reset.sp_after", sp, 8'hFA);

    pc = 16'h1234; psr = 8'h00; sp = 8'hFF;
    IRQ = 4'hE; irq_en = 4'h1; insn_boundary = 1'b1;
    run_seq("irq0", 1'b0, 8'h12, 8'h34, 8'h20, 16'hFFFE, 16'hA022, 4'h1, 1'b0, 0);

    IRQ = 4'hE; irq_en = 4'h1; i_flag = 1'b1; insn_boundary = 1'b1;
    tick();
    check("masked_i.busy", busy, 0);
    check("masked_i.valid", addr_valid, 0);
    i_flag = 1'b0; irq_en = 4'h0;
    tick();
    check("masked_en.busy", busy, 0);
    check("masked_en.valid", addr_valid, 0);
    IRQ = 4'hF; insn_boundary = 1'b0;

    pc = 16'hABCD; psr = 8'hC3; sp = 8'hF0;
    IRQ = 4'b0101; irq_en = 4'hF; insn_boundary = 1'b1;
    run_seq("irq1", 1'b0, 8'hAB, 8'hCD, 8'hE3, 16'hFFE0, 16'hB033, 4'b0010, 1'b0, 0);
    irq_en = 4'h0;

    pc = 16'h5678; psr = 8'h00; sp = 8'hE0;
    brk = 1'b1; insn_boundary = 1'b1;
    run_seq("brk_hijack", 1'b0, 8'h56, 8'h78, 8'h30, 16'hFFFA, 16'h9011, 4'h0, 1'b1, 0);
    NMI = 1'b1;
    insn_boundary = 1'b1;
    tick();
    check("hijack.no_pending", busy, 0);
    insn_boundary = 1'b0;

    pc = 16'h4321; psr = 8'h81; sp = 8'hC0;
    brk = 1'b1; NMI = 1'b0; insn_boundary = 1'b1;
    run_seq("nmi_vs_brk", 1'b0, 8'h43, 8'h21, 8'hA1, 16'hFFFA, 16'h9011, 4'h0, 1'b0, 0);
    NMI = 1'b1;

    pc = 16'h0202; psr = 8'h04; sp = 8'hD0;
    IRQ = 4'hE; irq_en = 4'h1; insn_boundary = 1'b1;
    run_seq("stall", 1'b0, 8'h02, 8'h02, 8'h24, 16'hFFFE, 16'hA022, 4'h1, 1'b0, 3);

    pc = 16'h0303; psr = 8'h00; sp = 8'hB0;
    IRQ = 4'hE; irq_en = 4'h1; insn_boundary = 1'b1;
    tick();
    insn_boundary = 1'b0; IRQ = 4'hF;
    tick();
    tick();
    check("abort.in_push_p", addr, 16'h01AE);
    RST_N = 1'b0;
    tick();
    check("abort.pc_load", pc_load, 0);
    check("abort.busy", busy, 1);
    check("abort.valid", addr_valid, 0);
    RST_N = 1'b1;
    irq_en = 4'h0;
    run_seq("reset2", 1'b1, 8'h00, 8'h00, 8'h00, 16'hFFFC, 16'h8000, 4'h0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Parametrised 6502-class interrupt/reset sequencer sitting beside the instruction decoder in tinymos6502.
- Arbitrates RESET, NMI, BRK and N_IRQ maskable IRQ channels.
- Runs the 7-cycle push-PC/push-P/fetch-vector sequence and hands the decoder a new PC.
- Generalises the single IRQ pin to multiple prioritised, individually enabled channels with per-channel vectors, and supports NMI hijack.

Parameters:
DATA_WIDTH, 8, data bus width; address width is 2*DATA_WIDTH
N_IRQ, 1, maskable IRQ channels, legal 1..13
STACK_PAGE, 8'h01, high address byte for stack pushes
EXT_VEC_BASE, 16'hFFE0, vector for IRQ channel 1; channel k≥1 uses EXT_VEC_BASE+2*(k-1)

Ports:
CLK  in  1  clock
RST_N  in  1  synchronous active-low reset
RDY  in  1  high = advance; low = freeze state and all outputs
NMI  in  1  active-low, falling-edge triggered
IRQ  in  N_IRQ  active-low level requests, bit 0 = highest priority
irq_en  in  N_IRQ  per-channel enable
i_flag  in  1  PSR interrupt-disable bit
insn_boundary  in  1  decoder at opcode-fetch point
brk  in  1  BRK decoded (valid with insn_boundary)
pc  in  2*DATA_WIDTH  current PC
psr  in  DATA_WIDTH  current PSR
sp  in  DATA_WIDTH  current stack pointer
data_in  in  DATA_WIDTH  read data (vector bytes)
busy  out  1  sequence active; decoder stalls
addr  out  2*DATA_WIDTH  bus address
addr_valid  out  1  addr meaningful
rw  out  1  1 = read, 0 = write
data_out  out  DATA_WIDTH  push data
sp_dec  out  1  one-cycle SP decrement strobe
pc_load  out  1  one-cycle strobe; load pc_new
pc_new  out  2*DATA_WIDTH  vector fetched
set_i  out  1  set I flag (same cycle as pc_load)
irq_ack  out  N_IRQ  one-hot acknowledge pulse for the serviced channel

Behaviour:
- States: IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, DONE. Each state lasts 1 cycle while RDY=1 and holds while RDY=0.
- Reset (RST_N=0 at an edge):
  - State ← IDLE, reset_pending ← 1, nmi_pending ← 0, NMI sample register ← 1.
  - Outputs: busy=1 (busy = state≠IDLE or reset_pending), addr_valid=0, rw=1, data_out=0, sp_dec=0, pc_load=0, set_i=0, irq_ack=0, pc_new=0.
  - RST_N low mid-sequence aborts immediately with no pc_load.
- Start, evaluated in IDLE:
  - reset_pending starts a sequence on the first cycle after reset, with no boundary needed.
  - Otherwise a sequence starts only when insn_boundary=1.
  - Priority: RESET > NMI (nmi_pending) > BRK > IRQ.
  - An IRQ is taken if any channel k has IRQ[k]=0, irq_en[k]=1 and i_flag=0. The lowest k wins.
  - The start is decided at cycle T0; PUSH_PCH occurs at T1.
- Push states:
  - addr = {STACK_PAGE, sp}, addr_valid=1, sp_dec=1.
  - data_out = pc high byte, then pc low byte, then P.
  - P = psr with bit5=1; bit4=1 only for BRK.
  - rw=0, except during a RESET sequence, where rw=1 (dummy reads) but sp_dec still pulses 3 times.
- Vector states: rw=1, addr_valid=1, addr = vector then vector+1. data_in is latched at the end of VEC_LO (low byte) and VEC_HI (high byte).
- Vector map:
  - NMI = FFFA
  - RESET = FFFC
  - BRK and IRQ channel 0 = FFFE
  - channel k≥1 = EXT_VEC_BASE+2*(k-1)
- DONE (T6):
  - pc_load=1, pc_new={hi,lo}, set_i=1.
  - irq_ack[k]=1 if the sequence was IRQ channel k.
  - reset_pending cleared; next state IDLE, with busy low at T7.
- NMI detection:
  - NMI is registered each cycle regardless of RDY.
  - A sample of 1 followed by 0 sets nmi_pending, which holds until consumed.
  - nmi_pending is consumed on entering an NMI sequence, or on hijack.
- NMI hijack:
  - If nmi_pending is set while in PUSH_PCH..PUSH_P of a BRK/IRQ sequence, the vector switches to FFFA and nmi_pending clears.
  - The pushed B bit is unchanged; no irq_ack is given.
- Other events:
  - An NMI edge during an NMI or RESET sequence stays pending for the next boundary.
  - An IRQ deasserting after start does not abort the sequence.
  - An NMI edge and brk in the same cycle: NMI wins; BRK is re-decoded by the decoder later.

Test Plan:
- Release RST_N with sp=8'hFD and mem[FFFC]=00, mem[FFFD]=80:
  - T1..T3: rw=1, sp_dec pulses ×3 (three cycles).
  - T4/T5: addr FFFC then FFFD.
  - T6: pc_load with pc_new=8000, set_i=1.
- pc=1234, psr=8'h00, sp=FF, IRQ[0]=0, irq_en=1, i_flag=0, insn_boundary=1:
  - writes 12@01FF, 34@01FE, 20@01FD (P with bit5=1, bit4=0), then reads FFFE/FFFF.
  - irq_ack=1 at T6.
- Same IRQ stimulus but i_flag=1 → busy stays 0 and no bus activity. IRQ[0]=0 with irq_en=0 → likewise ignored.
- N_IRQ=4, IRQ=4'b0101, irq_en=4'hF → channel 1 is serviced, vector FFE0/FFE1, irq_ack=4'b0010.
- BRK with psr=8'h00; NMI falls during PUSH_PCL → P pushed=30, vector fetch from FFFA, nmi_pending clears, irq_ack=0.
- During an IRQ sequence, hold RDY=0 for 3 cycles in VEC_LO → addr and state frozen, pc_load is delayed exactly 3 cycles to T9. Repeat with RST_N pulsed low in PUSH_P → no pc_load; reset sequence restarts.
